// File: rtl/rsp_s1_prep_ahbic_in_stage_if.sv
// AHB-Lite port bundle for the rsp_s1_prep interconnect input stage.
// Collects the master-side address phase and return path, the arbiter handshake,
// and the address phase that is forwarded to the output stage.
// slave  : view of the input stage, which is the slave of the upstream master.
// master : view of the upstream master, the arbiter and the output stage.
interface rsp_s1_prep_ahbic_in_stage_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    // Master-side address phase and data-phase return.
    logic                  HSELS;
    logic [ADDR_WIDTH-1:0] HADDRS;
    logic [1:0]            HTRANSS;
    logic                  HWRITES;
    logic [2:0]            HSIZES;
    logic [2:0]            HBURSTS;
    logic [3:0]            HPROTS;
    logic                  HMASTLOCKS;
    logic                  HREADYS;
    logic                  HREADYOUTS;
    logic                  HRESPS;

    // Arbiter handshake and shared-slave data-phase response.
    logic                  active_port;
    logic                  req_port;
    logic                  HREADYM;
    logic                  HRESPM;

    // Address phase forwarded to the output stage.
    logic                  HSELM;
    logic [ADDR_WIDTH-1:0] HADDRM;
    logic [1:0]            HTRANSM;
    logic                  HWRITEM;
    logic [2:0]            HSIZEM;
    logic [2:0]            HBURSTM;
    logic [3:0]            HPROTM;
    logic                  HMASTLOCKM;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        input  active_port, HREADYM, HRESPM,
        output HREADYOUTS, HRESPS, req_port,
        output HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        output active_port, HREADYM, HRESPM,
        input  HREADYOUTS, HRESPS, req_port,
        input  HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM
    );
endinterface

// File: rtl/rsp_s1_prep_ahbic_in_stage.sv
// AHB-Lite input stage of the rsp_s1_prep interconnect.
// Holds an address phase that cannot be issued at once, requests the arbiter,
// replays the held transfer when granted and stalls the master until the
// transfer's data phase completes on the shared slave.
// Build option RSP_S1_PREP_AHBIC_IN_REG_EN: remove the zero-latency bypass so
// every transfer goes through the hold register and the M outputs are registered.
module rsp_s1_prep_ahbic_in_stage #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                              HCLK,
    input  logic                              HRESETn,
    rsp_s1_prep_ahbic_in_stage_if.slave       ahb
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            trans;
        logic                  write;
        logic [2:0]            size;
        logic [2:0]            burst;
        logic [3:0]            prot;
        logic                  lock;
    } addr_phase_t;

    addr_phase_t live_ap;
    addr_phase_t hold_q;
    addr_phase_t mux_ap;
    logic        pend_q;
    logic        dphase_q;
    logic        sel_rdy;
    logic        live_tran;
    logic        issue;
    logic        capture;

    assign live_ap = {ahb.HADDRS, ahb.HTRANSS, ahb.HWRITES, ahb.HSIZES,
                      ahb.HBURSTS, ahb.HPROTS, ahb.HMASTLOCKS};

    assign sel_rdy   = ahb.HSELS & ahb.HREADYS;
    assign live_tran = sel_rdy & ahb.HTRANSS[1];

`ifdef RSP_S1_PREP_AHBIC_IN_REG_EN
    // Only the hold register can issue; every live transfer is captured.
    assign issue   = ahb.active_port & ahb.HREADYM & pend_q;
    assign capture = live_tran;
`else
    // A granted live transfer bypasses the hold register.
    assign issue   = ahb.active_port & ahb.HREADYM & (pend_q | live_tran);
    assign capture = live_tran & ~issue;
`endif

    // Hold register, pending flag and data-phase ownership.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_q   <= '0;
            pend_q   <= 1'b0;
            dphase_q <= 1'b0;
        end else begin
            if (capture) begin
                hold_q <= live_ap;
            end
            pend_q   <= capture | (pend_q & ~issue);
            dphase_q <= issue | (dphase_q & ~ahb.HREADYM);
        end
    end

    assign ahb.req_port = pend_q | live_tran;

`ifdef RSP_S1_PREP_AHBIC_IN_REG_EN
    // Output stage sees only registered address phase.
    assign mux_ap      = hold_q;
    assign ahb.HTRANSM = pend_q ? hold_q.trans : 2'b00;
    assign ahb.HSELM   = pend_q;
`else
    // Held transfer has priority over the live address phase.
    assign mux_ap      = pend_q ? hold_q : live_ap;
    assign ahb.HTRANSM = (pend_q | sel_rdy) ? mux_ap.trans : 2'b00;
    assign ahb.HSELM   = ahb.req_port;
`endif

    assign ahb.HADDRM     = mux_ap.addr;
    assign ahb.HWRITEM    = mux_ap.write;
    assign ahb.HSIZEM     = mux_ap.size;
    assign ahb.HBURSTM    = mux_ap.burst;
    assign ahb.HPROTM     = mux_ap.prot;
    assign ahb.HMASTLOCKM = mux_ap.lock;

    // Master is stalled while a transfer is held, then follows the slave.
    assign ahb.HREADYOUTS = dphase_q ? ahb.HREADYM : ~pend_q;
    assign ahb.HRESPS     = dphase_q & ahb.HRESPM;

endmodule

// File: tb/tb_rsp_s1_prep_ahbic_in_stage.sv
// Directed bench for rsp_s1_prep_ahbic_in_stage.
module tb_rsp_s1_prep_ahbic_in_stage;

    logic HCLK;
    logic HRESETn;
    int   checks;
    int   failures;

    rsp_s1_prep_ahbic_in_stage_if #(.ADDR_WIDTH(32)) ahb ();

    rsp_s1_prep_ahbic_in_stage #(.ADDR_WIDTH(32)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .ahb     (ahb)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        ahb.HSELS      = 1'b0;
        ahb.HADDRS     = 32'h0;
        ahb.HTRANSS    = 2'b00;
        ahb.HWRITES    = 1'b0;
        ahb.HSIZES     = 3'b000;
        ahb.HBURSTS    = 3'b000;
        ahb.HPROTS     = 4'b0000;
        ahb.HMASTLOCKS = 1'b0;
        ahb.HREADYS    = 1'b1;
    endtask

    task automatic drive_tran(input logic [31:0] a, input logic [1:0] t, input logic w);
        ahb.HSELS      = 1'b1;
        ahb.HREADYS    = 1'b1;
        ahb.HADDRS     = a;
        ahb.HTRANSS    = t;
        ahb.HWRITES    = w;
        ahb.HSIZES     = 3'b010;
        ahb.HBURSTS    = 3'b000;
        ahb.HPROTS     = 4'b0011;
        ahb.HMASTLOCKS = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        idle_inputs();
        ahb.active_port = 1'b0;
        ahb.HREADYM     = 1'b1;
        ahb.HRESPM      = 1'b0;
        repeat (2) tick();
        checks++; if (ahb.HREADYOUTS !== 1'b1) begin failures++; $display("FAIL rst_hreadyouts got=%0h exp=1", ahb.HREADYOUTS); end
        checks++; if (ahb.HRESPS !== 1'b0) begin failures++; $display("FAIL rst_hresps got=%0h exp=0", ahb.HRESPS); end
        checks++; if (ahb.req_port !== 1'b0) begin failures++; $display("FAIL rst_req_port got=%0h exp=0", ahb.req_port); end
        checks++; if (ahb.HSELM !== 1'b0) begin failures++; $display("FAIL rst_hselm got=%0h exp=0", ahb.HSELM); end
        checks++; if (ahb.HTRANSM !== 2'b00) begin failures++; $display("FAIL rst_htransm got=%0h exp=0", ahb.HTRANSM); end
        checks++; if (ahb.HADDRM !== 32'h0) begin failures++; $display("FAIL rst_haddrm got=%0h exp=0", ahb.HADDRM); end
        HRESETn = 1'b1;
        tick();

        // Hold a transfer at 0x100, then reset while it is pending.
        drive_tran(32'h100, 2'b10, 1'b0);
        #1;
        checks++; if (ahb.req_port !== 1'b1) begin failures++; $display("FAIL midrst_req got=%0h exp=1", ahb.req_port); end
        tick();
        idle_inputs();
        ahb.HREADYS = 1'b0;
        #1;
        checks++; if (ahb.HREADYOUTS !== 1'b0) begin failures++; $display("FAIL midrst_stall got=%0h exp=0", ahb.HREADYOUTS); end
        checks++; if (ahb.HADDRM !== 32'h100) begin failures++; $display("FAIL midrst_hold_addr got=%0h exp=100", ahb.HADDRM); end
        HRESETn = 1'b0;
        #1;
        checks++; if (ahb.HREADYOUTS !== 1'b1) begin failures++; $display("FAIL midrst_hreadyouts got=%0h exp=1", ahb.HREADYOUTS); end
        checks++; if (ahb.req_port !== 1'b0) begin failures++; $display("FAIL midrst_req_clr got=%0h exp=0", ahb.req_port); end
        checks++; if (ahb.HTRANSM !== 2'b00) begin failures++; $display("FAIL midrst_htransm got=%0h exp=0", ahb.HTRANSM); end
        checks++; if (ahb.HADDRM !== 32'h0) begin failures++; $display("FAIL midrst_haddrm got=%0h exp=0", ahb.HADDRM); end
        tick();
        HRESETn         = 1'b1;
        ahb.HREADYS     = 1'b1;
        ahb.active_port = 1'b1;
        #1;
        checks++; if (ahb.HSELM !== 1'b0) begin failures++; $display("FAIL postrst_hselm got=%0h exp=0", ahb.HSELM); end
        checks++; if (ahb.HTRANSM !== 2'b00) begin failures++; $display("FAIL postrst_htransm got=%0h exp=0", ahb.HTRANSM); end
        tick();
        // A dropped transfer would have set data-phase ownership and followed HREADYM.
        ahb.HREADYM = 1'b0;
        #1;
        checks++; if (ahb.HREADYOUTS !== 1'b1) begin failures++; $display("FAIL postrst_no_issue got=%0h exp=1", ahb.HREADYOUTS); end
        ahb.HREADYM = 1'b1;
    endtask

    task automatic test_bypass();
        ahb.active_port = 1'b1;
        ahb.HREADYM     = 1'b1;
        drive_tran(32'h2000_0010, 2'b10, 1'b1);
        #1;
        checks++; if (ahb.HADDRM !== 32'h2000_0010) begin failures++; $display("FAIL byp_haddrm got=%0h exp=20000010", ahb.HADDRM); end
        checks++; if (ahb.HTRANSM !== 2'b10) begin failures++; $display("FAIL byp_htransm got=%0h exp=2", ahb.HTRANSM); end
        checks++; if (ahb.HWRITEM !== 1'b1) begin failures++; $display("FAIL byp_hwritem got=%0h exp=1", ahb.HWRITEM); end
        checks++; if (ahb.HSELM !== 1'b1) begin failures++; $display("FAIL byp_hselm got=%0h exp=1", ahb.HSELM); end
        checks++; if (ahb.HREADYOUTS !== 1'b1) begin failures++; $display("FAIL byp_ready_addr got=%0h exp=1", ahb.HREADYOUTS); end
        tick();
        idle_inputs();
        ahb.HREADYM = 1'b0;
        #1;
        checks++; if (ahb.HREADYOUTS !== 1'b0) begin failures++; $display("FAIL byp_dphase_wait got=%0h exp=0", ahb.HREADYOUTS); end
        checks++; if (ahb.HTRANSM !== 2'b00) begin failures++; $display("FAIL byp_idle_htransm got=%0h exp=0", ahb.HTRANSM); end
        ahb.HREADYM = 1'b1;
        #1;
        checks++; if (ahb.HREADYOUTS !== 1'b1) begin failures++; $display("FAIL byp_dphase_done got=%0h exp=1", ahb.HREADYOUTS); end
        tick();
        ahb.HREADYM = 1'b0;
        #1;
        checks++; if (ahb.HREADYOUTS !== 1'b1) begin failures++; $display("FAIL byp_dphase_clr got=%0h exp=1", ahb.HREADYOUTS); end
        ahb.HREADYM = 1'b1;
    endtask

    task automatic test_held();
        ahb.active_port = 1'b0;
        ahb.HREADYM     = 1'b1;
        drive_tran(32'h40, 2'b10, 1'b0);
        #1;
        checks++; if (ahb.req_port !== 1'b1) begin failures++; $display("FAIL held_req got=%0h exp=1", ahb.req_port); end
        checks++; if (ahb.HREADYOUTS !== 1'b1) begin failures++; $display("FAIL held_ready_c0 got=%0h exp=1", ahb.HREADYOUTS); end
        tick();
        idle_inputs();
        ahb.HREADYS = 1'b0;
        ahb.HADDRS  = 32'hDEAD_BEE0;
        #1;
        checks++; if (ahb.HREADYOUTS !== 1'b0) begin failures++; $display("FAIL held_stall_c1 got=%0h exp=0", ahb.HREADYOUTS); end
        checks++; if (ahb.req_port !== 1'b1) begin failures++; $display("FAIL held_req_c1 got=%0h exp=1", ahb.req_port); end
        checks++; if (ahb.HADDRM !== 32'h40) begin failures++; $display("FAIL held_addr_c1 got=%0h exp=40", ahb.HADDRM); end
        tick();
        #1;
        checks++; if (ahb.HREADYOUTS !== 1'b0) begin failures++; $display("FAIL held_stall_c2 got=%0h exp=0", ahb.HREADYOUTS); end
        tick();
        ahb.active_port = 1'b1;
        #1;
        checks++; if (ahb.HADDRM !== 32'h40) begin failures++; $display("FAIL held_issue_addr got=%0h exp=40", ahb.HADDRM); end
        checks++; if (ahb.HTRANSM !== 2'b10) begin failures++; $display("FAIL held_issue_htransm got=%0h exp=2", ahb.HTRANSM); end
        checks++; if (ahb.HWRITEM !== 1'b0) begin failures++; $display("FAIL held_issue_hwritem got=%0h exp=0", ahb.HWRITEM); end
        checks++; if (ahb.HREADYOUTS !== 1'b0) begin failures++; $display("FAIL held_issue_stall got=%0h exp=0", ahb.HREADYOUTS); end
        tick();
        ahb.HREADYM = 1'b0;
        #1;
        checks++; if (ahb.HREADYOUTS !== 1'b0) begin failures++; $display("FAIL held_dphase_wait got=%0h exp=0", ahb.HREADYOUTS); end
        checks++; if (ahb.HSELM !== 1'b0) begin failures++; $display("FAIL held_no_reissue got=%0h exp=0", ahb.HSELM); end
        tick();
        ahb.HREADYM = 1'b1;
        #1;
        checks++; if (ahb.HREADYOUTS !== 1'b1) begin failures++; $display("FAIL held_dphase_done got=%0h exp=1", ahb.HREADYOUTS); end
        tick();
        idle_inputs();
    endtask

    task automatic test_error();
        ahb.active_port = 1'b1;
        ahb.HREADYM     = 1'b1;
        ahb.HRESPM      = 1'b1;
        drive_tran(32'h80, 2'b10, 1'b0);
        #1;
        checks++; if (ahb.HRESPS !== 1'b0) begin failures++; $display("FAIL err_no_dphase got=%0h exp=0", ahb.HRESPS); end
        tick();
        idle_inputs();
        ahb.HREADYM = 1'b0;
        #1;
        checks++; if (ahb.HRESPS !== 1'b1) begin failures++; $display("FAIL err_resp_c1 got=%0h exp=1", ahb.HRESPS); end
        checks++; if (ahb.HREADYOUTS !== 1'b0) begin failures++; $display("FAIL err_ready_c1 got=%0h exp=0", ahb.HREADYOUTS); end
        tick();
        ahb.HREADYM = 1'b1;
        #1;
        checks++; if (ahb.HRESPS !== 1'b1) begin failures++; $display("FAIL err_resp_c2 got=%0h exp=1", ahb.HRESPS); end
        checks++; if (ahb.HREADYOUTS !== 1'b1) begin failures++; $display("FAIL err_ready_c2 got=%0h exp=1", ahb.HREADYOUTS); end
        tick();
        #1;
        checks++; if (ahb.HRESPS !== 1'b0) begin failures++; $display("FAIL err_resp_after got=%0h exp=0", ahb.HRESPS); end
        ahb.HRESPM = 1'b0;
    endtask

    task automatic test_burst();
        logic [31:0] got [4];
        logic [1:0]  first_trans;
        logic        adv;
        int          n;
        int          b;
        n = 0;
        b = 0;
        first_trans = 2'b00;
        ahb.active_port = 1'b1;
        ahb.HRESPM      = 1'b0;
        for (int c = 0; c < 12 && n < 4; c++) begin
            ahb.HREADYM = (c == 2) ? 1'b0 : 1'b1;
            if (b < 4) begin
                drive_tran(32'(b * 4), (b == 0) ? 2'b10 : 2'b11, 1'b1);
                ahb.HBURSTS = 3'b011;
            end else begin
                idle_inputs();
            end
            #1;
            ahb.HREADYS = ahb.HREADYOUTS;
            #1;
            if (ahb.active_port && ahb.HREADYM && ahb.HSELM && ahb.HTRANSM[1]) begin
                if (n == 0) first_trans = ahb.HTRANSM;
                got[n] = ahb.HADDRM;
                n++;
            end
            adv = ahb.HREADYS;
            tick();
            if (adv && b < 4) b++;
        end
        checks++; if (n != 4) begin failures++; $display("FAIL burst_count got=%0d exp=4", n); end
        checks++; if (first_trans !== 2'b10) begin failures++; $display("FAIL burst_first_nonseq got=%0h exp=2", first_trans); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== 32'(i * 4)) begin
                failures++;
                $display("FAIL burst_addr%0d got=%0h exp=%0h", i, got[i], i * 4);
            end
        end
        idle_inputs();
        ahb.HREADYM = 1'b1;
        tick();
    endtask

    task automatic test_reg_en();
        ahb.active_port = 1'b1;
        ahb.HREADYM     = 1'b1;
        drive_tran(32'h2000_0010, 2'b10, 1'b1);
        #1;
        checks++; if (ahb.HTRANSM !== 2'b00) begin failures++; $display("FAIL regen_no_bypass got=%0h exp=0", ahb.HTRANSM); end
        checks++; if (ahb.req_port !== 1'b1) begin failures++; $display("FAIL regen_req got=%0h exp=1", ahb.req_port); end
        tick();
        idle_inputs();
        ahb.HREADYS = 1'b0;
        #1;
        checks++; if (ahb.HADDRM !== 32'h2000_0010) begin failures++; $display("FAIL regen_haddrm got=%0h exp=20000010", ahb.HADDRM); end
        checks++; if (ahb.HTRANSM !== 2'b10) begin failures++; $display("FAIL regen_htransm got=%0h exp=2", ahb.HTRANSM); end
        checks++; if (ahb.HREADYOUTS !== 1'b0) begin failures++; $display("FAIL regen_wait got=%0h exp=0", ahb.HREADYOUTS); end
        tick();
        ahb.HREADYS = 1'b1;
        #1;
        checks++; if (ahb.HREADYOUTS !== 1'b1) begin failures++; $display("FAIL regen_done got=%0h exp=1", ahb.HREADYOUTS); end
        checks++; if (ahb.HTRANSM !== 2'b00) begin failures++; $display("FAIL regen_idle got=%0h exp=0", ahb.HTRANSM); end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
`ifdef RSP_S1_PREP_AHBIC_IN_REG_EN
        test_reg_en();
`else
        test_bypass();
        test_held();
        test_error();
        test_burst();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsp_s1_prep_ahbic_in_stage.md
# rsp_s1_prep_ahbic_in_stage

AHB-Lite input stage for the rsp_s1_prep AHB interconnect: sits between an upstream master port and the output-stage arbiter. It registers an address phase that cannot be issued immediately and raises `req_port` towards the arbiter. It replays the held transfer once granted and inserts wait states on the master side until that transfer reaches the slave. It returns the slave's data-phase HREADYOUT/HRESP to the master.

## Interface
- `ADDR_WIDTH`, 32, address width of HADDRS/HADDRM
- `HCLK`  in  1  AHB clock
- `HRESETn`  in  1  reset; asynchronous, active-low
- `HSELS`  in  1  port select from master side
- `HADDRS`  in  ADDR_WIDTH  address
- `HTRANSS`  in  2  transfer type
- `HWRITES`  in  1  write
- `HSIZES`  in  3  size
- `HBURSTS`  in  3  burst
- `HPROTS`  in  4  protection
- `HMASTLOCKS`  in  1  locked transfer
- `HREADYS`  in  1  master-side HREADY (transfer done)
- `HREADYOUTS`  out  1  ready returned to master
- `HRESPS`  out  1  response returned to master
- `active_port`  in  1  grant from arbiter (port selected and no_port low)
- `HREADYM`  in  1  shared-slave HREADY
- `HRESPM`  in  1  shared-slave HRESP
- `req_port`  out  1  request to arbiter
- `HSELM`, `HADDRM`, `HTRANSM`, `HWRITEM`, `HSIZEM`, `HBURSTM`, `HPROTM`, `HMASTLOCKM`  out  widths as the S-side signals  address phase to output stage

## Operation
- `live_tran` = HSELS & HREADYS & HTRANSS[1] (NONSEQ/SEQ sampled).
- `issue` = active_port & HREADYM & (pend | live_tran).
- State registers: `pend` (held transfer waiting) and `dphase` (this port owns the slave data phase).
- Hold register captures all S-side address/control when live_tran & ~issue; pend <= 1.
- pend clears when issue; hold register content is unchanged until the next capture.
- dphase: set on issue; cleared on HREADYM & ~issue.
- req_port = pend | live_tran.
- Address mux: pend ? hold register : live S-side. HTRANSM = 2'b00 when neither pend nor (HSELS & HREADYS). HSELM = req_port.
- HMASTLOCKM follows the muxed source; locked sequences keep req_port asserted.
- HREADYOUTS = dphase ? HREADYM : ~pend.
- HRESPS = dphase & HRESPM. Two-cycle ERROR passes through unchanged.
- pend and dphase are never both 1: master is stalled while pend.
- Reset mid-transfer: all state clears, hold register zeroes, and the in-flight transfer is dropped.

## Timing
- Reset values: HREADYOUTS=1, HRESPS=0, req_port=0, HSELM=0, HTRANSM=2'b00, every other M output 0, pend=0, dphase=0.
- Bypass (granted, slave ready): 0-cycle address latency. Slave data phase is in the next cycle.
- Not granted: transfer held. HREADYOUTS low from the next cycle until the held transfer's data phase completes. Issue occurs in the first cycle with active_port & HREADYM.
- Grant is registered in the arbiter, so a fresh request from an idle arbiter costs 1 wait cycle.
- Simultaneous issue and new live_tran: the new transfer is issued; no capture.

## Configuration
- `RSP_S1_PREP_AHBIC_IN_REG_EN` defined: bypass path removed.
  - Every live_tran is captured into the hold register.
  - Issue only from pend, so address latency is always ≥1 cycle with at least 1 master wait state per transfer.
  - M outputs are fully registered, which improves timing.
- Undefined: zero-latency bypass as described above.

## Test plan
- Reset asserted mid-pend (HADDRS=0x100 held) → all outputs at reset values immediately; after release, no transfer issued.
- active_port=1, HREADYM=1, NONSEQ write to 0x2000_0010 → HADDRM=0x2000_0010 and HTRANSM=2'b10 in the same cycle; HREADYOUTS follows HREADYM next cycle.
- active_port=0, NONSEQ read to 0x40 → req_port=1 and HREADYOUTS=0. Raise active_port 3 cycles later → HADDRM=0x40 from the hold register; HREADYOUTS=1 when the slave completes.
- Slave returns ERROR (HRESPM=1, HREADYM=0 then 1) → HRESPS=1 for both cycles; HREADYOUTS=0 then 1.
- 4-beat INCR4 with HREADYM low 1 cycle on beat 2 → four issues, addresses 0x0/0x4/0x8/0xC in order, no duplicate or lost beat.
- With `RSP_S1_PREP_AHBIC_IN_REG_EN`, the bypass-case write → HADDRM valid 1 cycle later, with 1 master wait state.
